controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/controller_pkg.sv | 44 ++++
 rtl/controller_wait_timer.sv | 50 +++++
 rtl/controller.sv | 175 +++++++++++++++++
 tb/tb_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared definitions for the instruction-sequencing controller.
//
// Holds the FSM state encoding (also exported on the State debug port),
// the 4-bit operation codes found in Opcode[7:4], and the AluOp codes
// driven toward the datapath.  Benches import this package too, so the
// encodings only ever live in one place.
package controller_pkg;

   // Controller FSM states; the numeric values are visible on the State port
   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_LATCH  = 4'd2,
      ST_DECODE = 4'd3,
      ST_MEMRD  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_ACCWB  = 4'd6,
      ST_ALU    = 4'd7,
      ST_JUMP   = 4'd8,
      ST_HALT   = 4'd9,
      ST_ERROR  = 4'd10
   } state_e;

   // Operation field values (Opcode[7:4])
   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_JMP   = 4'h5;
   localparam logic [3:0] OP_JZ    = 4'h6;
   localparam logic [3:0] OP_HLT   = 4'hF;

   // ALU operation codes
   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;

   // States in which the controller is waiting on a MemReady strobe
   function automatic logic isWaitState(input state_e s);
      return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
   endfunction

endpackage

// File: rtl/controller_wait_timer.sv
// Memory wait-timeout counter.
//
// Counts cycles spent waiting on memory.  expired_o is raised in the cycle
// that would bring the count up to MAX_WAIT, so the controller can leave
// for ERROR on that same edge.  clear_i wins over enable_i.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset, clears the count
//   clear_i   restart the count from zero
//   enable_i  one more cycle spent waiting (no MemReady this cycle)
//   expired_o this waiting cycle is the MAX_WAIT-th one
module wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [7:0] LAST_COUNT = 8'(MAX_WAIT - 1);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // Next count: clearing has priority, otherwise advance while waiting
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + 8'd1;
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expired only in a waiting cycle that completes the MAX_WAIT budget
   assign expired_o = enable_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/controller.sv
// Moore-style instruction sequencing controller for a simple accumulator CPU.
//
// Walks FETCH/LATCH/DECODE and then the per-instruction execute states,
// returning to FETCH (or IDLE when Run is low) at each instruction
// boundary.  Memory accesses are guarded by a wait timer; a timeout or an
// unknown operation parks the FSM in ERROR, a HLT parks it in HALT.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   Run               enable, looked at only at instruction boundaries
//   Opcode            IR contents, [7:4] selects the operation
//   MemReady          memory completion strobe
//   Zero              accumulator-zero flag (for JZ)
//   LoadIR, IncPC     IR load / PC increment strobes
//   LoadPC            PC load strobe for jumps
//   MemRead, MemWrite memory request levels
//   LoadAcc, AluOp    accumulator write strobe and ALU function
//   Halted, Fault     sticky status flags
//   State             current state encoding for debug
module controller
   import controller_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Run,
   input  logic [7:0] Opcode,
   input  logic       MemReady,
   input  logic       Zero,
   output logic       LoadIR,
   output logic       IncPC,
   output logic       LoadPC,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       LoadAcc,
   output logic [1:0] AluOp,
   output logic       Halted,
   output logic       Fault,
   output logic [3:0] State
);

   state_e     state_q;
   state_e     state_d;
   logic [1:0] aluOp_q;
   logic [1:0] aluOp_d;
   logic       halted_q;
   logic       fault_q;

   logic       timerClear;
   logic       timerEnable;
   logic       timerExpired;
   logic [3:0] operation;
   state_e     boundaryState;
   logic       unusedOpcodeBits;

   assign operation        = Opcode[7:4];
   assign unusedOpcodeBits = ^Opcode[3:0];
   assign boundaryState    = Run ? ST_FETCH : ST_IDLE;

   // Restarting the timer on every state change also covers MEMWR -> FETCH,
   // where one wait state follows another directly.
   assign timerClear  = (state_d != state_q);
   assign timerEnable = isWaitState(state_q) && !MemReady;

   wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (timerClear),
      .enable_i  (timerEnable),
      .expired_o (timerExpired)
   );

   // Next-state logic.  MemReady is checked before the timeout so that a
   // strobe landing on the last allowed cycle still completes the access.
   always_comb begin
      state_d = state_q;
      aluOp_d = aluOp_q;
      unique case (state_q)
         ST_IDLE: begin
            if (Run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (MemReady)          state_d = ST_LATCH;
            else if (timerExpired) state_d = ST_ERROR;
         end
         ST_LATCH: begin
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            case (operation)
               OP_NOP:   state_d = boundaryState;
               OP_LOAD:  state_d = ST_MEMRD;
               OP_STORE: state_d = ST_MEMWR;
               OP_ADD: begin
                  state_d = ST_ALU;
                  aluOp_d = ALU_ADD;
               end
               OP_SUB: begin
                  state_d = ST_ALU;
                  aluOp_d = ALU_SUB;
               end
               OP_JMP:   state_d = ST_JUMP;
               OP_JZ:    state_d = Zero ? ST_JUMP : boundaryState;
               OP_HLT:   state_d = ST_HALT;
               default:  state_d = ST_ERROR;
            endcase
         end
         ST_MEMRD: begin
            if (MemReady)          state_d = ST_ACCWB;
            else if (timerExpired) state_d = ST_ERROR;
         end
         ST_MEMWR: begin
            if (MemReady)          state_d = boundaryState;
            else if (timerExpired) state_d = ST_ERROR;
         end
         ST_ACCWB, ST_ALU, ST_JUMP: begin
            state_d = boundaryState;
         end
         ST_HALT:  state_d = ST_HALT;
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_ERROR;
      endcase
   end

   // State, latched ALU function and sticky flags.  The flags are set on the
   // edge that enters HALT/ERROR so they are visible alongside that state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         aluOp_q  <= ALU_PASS;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         aluOp_q  <= aluOp_d;
         halted_q <= halted_q || (state_d == ST_HALT);
         fault_q  <= fault_q || (state_d == ST_ERROR);
      end
   end

   // Output decode from the registered state only
   always_comb begin
      LoadIR   = 1'b0;
      IncPC    = 1'b0;
      LoadPC   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      LoadAcc  = 1'b0;
      AluOp    = ALU_PASS;
      case (state_q)
         ST_FETCH: MemRead = 1'b1;
         ST_LATCH: begin
            LoadIR = 1'b1;
            IncPC  = 1'b1;
         end
         ST_MEMRD: MemRead  = 1'b1;
         ST_MEMWR: MemWrite = 1'b1;
         ST_ACCWB: LoadAcc  = 1'b1;
         ST_ALU: begin
            LoadAcc = 1'b1;
            AluOp   = aluOp_q;
         end
         ST_JUMP:  LoadPC = 1'b1;
         default: ;
      endcase
   end

   assign Halted = halted_q;
   assign Fault  = fault_q;
   assign State  = state_q;

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller, built with MAX_WAIT=3 so the timeout
// paths are short.  Expected values are hand-derived constants; output
// vector order is {LoadIR,IncPC,LoadPC,MemRead,MemWrite,LoadAcc,AluOp,Halted,Fault}.
module tb_controller;
   import controller_pkg::*;

   logic       clk;
   logic       reset;
   logic       Run;
   logic [7:0] Opcode;
   logic       MemReady;
   logic       Zero;
   logic       LoadIR;
   logic       IncPC;
   logic       LoadPC;
   logic       MemRead;
   logic       MemWrite;
   logic       LoadAcc;
   logic [1:0] AluOp;
   logic       Halted;
   logic       Fault;
   logic [3:0] State;

   int total = 0;
   int bad   = 0;
   logic checkEn = 1'b0;

   localparam logic [9:0] O_NONE  = 10'b00_0000_0000;
   localparam logic [9:0] O_FETCH = 10'b0001000000;
   localparam logic [9:0] O_LATCH = 10'b1100000000;
   localparam logic [9:0] O_MEMWR = 10'b0000100000;
   localparam logic [9:0] O_ACCWB = 10'b0000010000;
   localparam logic [9:0] O_ADD   = 10'b0000010100;
   localparam logic [9:0] O_SUB   = 10'b0000011000;
   localparam logic [9:0] O_JUMP  = 10'b0010000000;
   localparam logic [9:0] O_HALT  = 10'b0000000010;
   localparam logic [9:0] O_ERROR = 10'b0000000001;

   controller #(
      .MAX_WAIT (3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .Run      (Run),
      .Opcode   (Opcode),
      .MemReady (MemReady),
      .Zero     (Zero),
      .LoadIR   (LoadIR),
      .IncPC    (IncPC),
      .LoadPC   (LoadPC),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .LoadAcc  (LoadAcc),
      .AluOp    (AluOp),
      .Halted   (Halted),
      .Fault    (Fault),
      .State    (State)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Strobe exclusivity watched on every falling edge once reset has settled
   always @(negedge clk) begin
      if (checkEn) begin
         total++;
         assert (!(MemRead && MemWrite) && ($countones({LoadIR, LoadPC, LoadAcc}) <= 1))
         else begin
            bad++;
            $error("FAIL exclusive got=%b%b%b%b%b required=at-most-one", MemRead, MemWrite, LoadIR, LoadPC, LoadAcc);
         end
      end
   end

   task automatic applyStimulus(input logic run, input logic [7:0] op, input logic rdy, input logic zero);
      Run      = run;
      Opcode   = op;
      MemReady = rdy;
      Zero     = zero;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] expState, input logic [9:0] expOut);
      logic [9:0] obs;
      obs = {LoadIR, IncPC, LoadPC, MemRead, MemWrite, LoadAcc, AluOp, Halted, Fault};
      total++;
      assert (State === expState)
      else begin
         bad++;
         $error("FAIL %s state got=%0d required=%0d", tag, State, expState);
      end
      total++;
      assert (obs === expOut)
      else begin
         bad++;
         $error("FAIL %s outputs got=%b required=%b", tag, obs, expOut);
      end
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      checkEn = 1'b1;
      checkOutput("reset", ST_IDLE, O_NONE);
      reset = 1'b0;
      tick();
      checkOutput("idle_norun", ST_IDLE, O_NONE);

      // LOAD, MemReady one cycle after each request
      applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
      tick();  checkOutput("ld_fetch", ST_FETCH, O_FETCH);
      tick();  checkOutput("ld_fetch_wait", ST_FETCH, O_FETCH);
      MemReady = 1'b1;
      tick();  checkOutput("ld_latch", ST_LATCH, O_LATCH);
      MemReady = 1'b0;
      tick();  checkOutput("ld_decode", ST_DECODE, O_NONE);
      tick();  checkOutput("ld_memrd", ST_MEMRD, O_FETCH);
      tick();  checkOutput("ld_memrd_wait", ST_MEMRD, O_FETCH);
      MemReady = 1'b1;
      tick();  checkOutput("ld_accwb", ST_ACCWB, O_ACCWB);
      MemReady = 1'b0;
      tick();  checkOutput("ld_refetch", ST_FETCH, O_FETCH);

      // NOP: three edges from FETCH back to FETCH
      applyStimulus(1'b1, 8'h0A, 1'b1, 1'b0);
      tick();  checkOutput("nop_latch", ST_LATCH, O_LATCH);
      MemReady = 1'b0;
      tick();  checkOutput("nop_decode", ST_DECODE, O_NONE);
      tick();  checkOutput("nop_refetch", ST_FETCH, O_FETCH);

      // ADD and SUB pick up the latched ALU function
      applyStimulus(1'b1, 8'h35, 1'b1, 1'b0);
      tick();  MemReady = 1'b0;
      tick();  checkOutput("add_decode", ST_DECODE, O_NONE);
      tick();  checkOutput("add_alu", ST_ALU, O_ADD);
      tick();  checkOutput("add_refetch", ST_FETCH, O_FETCH);
      applyStimulus(1'b1, 8'h40, 1'b1, 1'b0);
      tick();  MemReady = 1'b0;
      tick();
      tick();  checkOutput("sub_alu", ST_ALU, O_SUB);
      tick();  checkOutput("sub_refetch", ST_FETCH, O_FETCH);

      // JZ not taken, then taken
      applyStimulus(1'b1, 8'h60, 1'b1, 1'b0);
      tick();  MemReady = 1'b0;
      tick();  checkOutput("jz0_decode", ST_DECODE, O_NONE);
      tick();  checkOutput("jz0_refetch", ST_FETCH, O_FETCH);
      applyStimulus(1'b1, 8'h60, 1'b1, 1'b1);
      tick();  MemReady = 1'b0;
      tick();
      tick();  checkOutput("jz1_jump", ST_JUMP, O_JUMP);
      tick();  checkOutput("jz1_refetch", ST_FETCH, O_FETCH);

      // JMP: four edges from FETCH back to FETCH
      applyStimulus(1'b1, 8'h50, 1'b1, 1'b0);
      tick();  MemReady = 1'b0;
      tick();
      tick();  checkOutput("jmp_jump", ST_JUMP, O_JUMP);
      tick();  checkOutput("jmp_refetch", ST_FETCH, O_FETCH);

      // STORE with Run dropped mid-write completes then idles
      applyStimulus(1'b1, 8'h20, 1'b1, 1'b0);
      tick();  MemReady = 1'b0;
      tick();
      tick();  checkOutput("st_memwr", ST_MEMWR, O_MEMWR);
      Run = 1'b0;
      tick();  checkOutput("st_memwr_wait", ST_MEMWR, O_MEMWR);
      MemReady = 1'b1;
      tick();  checkOutput("st_idle", ST_IDLE, O_NONE);

      // Fetch timeout after three cycles without MemReady
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      tick();  checkOutput("to_fetch", ST_FETCH, O_FETCH);
      tick();
      tick();  checkOutput("to_fetch_c2", ST_FETCH, O_FETCH);
      tick();  checkOutput("to_error", ST_ERROR, O_ERROR);
      MemReady = 1'b1;
      tick();  checkOutput("to_error_stuck", ST_ERROR, O_ERROR);
      reset = 1'b1;
      tick();  checkOutput("to_reset", ST_IDLE, O_NONE);
      reset = 1'b0;

      // MemReady on the third waiting cycle wins over the timeout
      applyStimulus(1'b1, 8'h70, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      MemReady = 1'b1;
      tick();  checkOutput("win_latch", ST_LATCH, O_LATCH);
      MemReady = 1'b0;
      tick();  checkOutput("bad_decode", ST_DECODE, O_NONE);
      tick();  checkOutput("bad_error", ST_ERROR, O_ERROR);
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // Reset in the middle of a memory read drops the request
      applyStimulus(1'b1, 8'h10, 1'b1, 1'b0);
      tick();
      tick();  MemReady = 1'b0;
      tick();
      tick();  checkOutput("rst_memrd", ST_MEMRD, O_FETCH);
      reset = 1'b1;
      tick();  checkOutput("rst_midread", ST_IDLE, O_NONE);
      reset = 1'b0;

      // HLT is absorbing until reset
      applyStimulus(1'b1, 8'hF0, 1'b1, 1'b0);
      tick();
      tick();  MemReady = 1'b0;
      tick();
      tick();  checkOutput("hlt_halt", ST_HALT, O_HALT);
      for (int i = 0; i < 4; i++) begin
         MemReady = ~MemReady;
         tick();
      end
      checkOutput("hlt_stuck", ST_HALT, O_HALT);
      reset = 1'b1;
      tick();  checkOutput("hlt_reset", ST_IDLE, O_NONE);
      reset = 1'b0;
      Run = 1'b0;
      tick();  checkOutput("hlt_after", ST_IDLE, O_NONE);

      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
